// File: rtl/riscv_l2_arbiter.sv
// riscv_l2_arbiter
//   Arbitrates the I-side (read-only) and D-side (read/write) L1 miss ports
//   onto a single L2 port. One transaction is in flight at a time:
//   IDLE -> BUSY (L2 strobe held) -> RESP (one-cycle ready pulse) -> IDLE.
//   A BUSY phase that sees no l2_ready for TIMEOUT cycles completes with
//   err=1 and rdata=0 for the owning side.
//
// Configuration macro:
//   L2_ARB_RR_EN  defined   : round-robin on conflict (I wins the first one
//                             after reset).
//                 undefined : fixed priority, D always wins on conflict.
//
// Parameters:
//   TIMEOUT   max BUSY cycles waiting for l2_ready (2..65535)
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   ic_req, ic_addr                I-side read request / address
//   ic_rdata, ic_ready, ic_err     I-side response (ready is a 1-cycle pulse)
//   dc_req, dc_we, dc_addr,
//   dc_wdata                       D-side request (we=1 write, 0 read)
//   dc_rdata, dc_ready, dc_err     D-side response
//   l2_addr, l2_wdata,
//   l2_read, l2_write              registered L2 request
//   l2_rdata, l2_ready             L2 response
//   busy                           state is not IDLE
module riscv_l2_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_rdata,
  output logic        ic_ready,
  output logic        ic_err,
  input  logic        dc_req,
  input  logic        dc_we,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  output logic [31:0] dc_rdata,
  output logic        dc_ready,
  output logic        dc_err,
  output logic [31:0] l2_addr,
  output logic [31:0] l2_wdata,
  output logic        l2_read,
  output logic        l2_write,
  input  logic [31:0] l2_rdata,
  input  logic        l2_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        owner_d;   // 1: D-side owns the in-flight transaction
  logic        owner_we;  // latched write-enable of the owner
  logic [15:0] tmo_cnt;
  logic        grant_d;
  logic        tmo_hit;

`ifdef L2_ARB_RR_EN
  logic        last_grant_d;  // 1: D-side received the most recent grant

  // On conflict the side that did not win last time gets the bus.
  always_comb begin
    grant_d = dc_req;
    if (ic_req && dc_req) begin
      grant_d = ~last_grant_d;
    end
  end
`else
  // Fixed priority: D-side wins any conflict.
  always_comb begin
    grant_d = dc_req;
  end
`endif

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner_d  <= 1'b0;
      owner_we <= 1'b0;
      tmo_cnt  <= 16'd0;
      ic_rdata <= 32'd0;
      ic_ready <= 1'b0;
      ic_err   <= 1'b0;
      dc_rdata <= 32'd0;
      dc_ready <= 1'b0;
      dc_err   <= 1'b0;
      l2_addr  <= 32'd0;
      l2_wdata <= 32'd0;
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
      busy     <= 1'b0;
`ifdef L2_ARB_RR_EN
      last_grant_d <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ic_req || dc_req) begin
            // The latch of the request lives directly in the registered
            // L2 outputs; later changes on ic_*/dc_* cannot reach them.
            owner_d  <= grant_d;
            owner_we <= grant_d & dc_we;
            l2_addr  <= grant_d ? dc_addr : ic_addr;
            l2_wdata <= grant_d ? dc_wdata : 32'd0;
            l2_read  <= ~(grant_d & dc_we);
            l2_write <= grant_d & dc_we;
            tmo_cnt  <= 16'd0;
            busy     <= 1'b1;
            state    <= BUSY;
`ifdef L2_ARB_RR_EN
            last_grant_d <= grant_d;
`endif
          end
        end

        BUSY: begin
          // A real completion takes precedence over a timeout in the same
          // cycle.
          if (l2_ready || tmo_hit) begin
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            state    <= RESP;
            if (owner_d) begin
              dc_ready <= 1'b1;
              dc_err   <= ~l2_ready;
              if (!l2_ready) begin
                dc_rdata <= 32'd0;
              end else if (!owner_we) begin
                dc_rdata <= l2_rdata;
              end
            end else begin
              ic_ready <= 1'b1;
              ic_err   <= ~l2_ready;
              ic_rdata <= l2_ready ? l2_rdata : 32'd0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        RESP: begin
          ic_ready <= 1'b0;
          ic_err   <= 1'b0;
          dc_ready <= 1'b0;
          dc_err   <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          l2_read  <= 1'b0;
          l2_write <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_l2_arbiter.sv
// tb_riscv_l2_arbiter
//   Randomized and directed stimulus for riscv_l2_arbiter. The driver keeps
//   a transaction-level model (who wins, what each side's rdata becomes,
//   how many strobe cycles occur) and pushes expectations into queues; an
//   independent monitor pops and compares whenever the DUT shows a BUSY
//   entry or a ready pulse.
module tb_riscv_l2_arbiter;

  localparam int TMO = 8;

  logic        clk;
  logic        rst_n;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_ready;
  logic        ic_err;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [31:0] dc_rdata;
  logic        dc_ready;
  logic        dc_err;
  logic [31:0] l2_addr;
  logic [31:0] l2_wdata;
  logic        l2_read;
  logic        l2_write;
  logic [31:0] l2_rdata;
  logic        l2_ready;
  logic        busy;

  riscv_l2_arbiter #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .ic_rdata (ic_rdata),
    .ic_ready (ic_ready),
    .ic_err   (ic_err),
    .dc_req   (dc_req),
    .dc_we    (dc_we),
    .dc_addr  (dc_addr),
    .dc_wdata (dc_wdata),
    .dc_rdata (dc_rdata),
    .dc_ready (dc_ready),
    .dc_err   (dc_err),
    .l2_addr  (l2_addr),
    .l2_wdata (l2_wdata),
    .l2_read  (l2_read),
    .l2_write (l2_write),
    .l2_rdata (l2_rdata),
    .l2_ready (l2_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          side;   // 1 = D
    bit          err;
    logic [31:0] ic_rd;
    logic [31:0] dc_rd;
    int          nb;     // expected number of strobe (BUSY) cycles
  } resp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } l2x_t;

  resp_t rq[$];
  l2x_t  lq[$];
  int    checks = 0;
  int    errors = 0;
  int    txn_no = 0;

  // Reference model state
`ifdef L2_ARB_RR_EN
  bit          m_last = 1'b1;
`endif
  logic [31:0] m_ic_rd = 32'd0;
  logic [31:0] m_dc_rd = 32'd0;
  bit          from_resp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit arb_pick(input bit i, input bit d);
`ifdef L2_ARB_RR_EN
    if (i && d) return ~m_last;
`endif
    return d;
  endfunction

  // One complete transaction. lat = BUSY cycle (1-based) in which l2_ready
  // is raised; 0 means never.
  task automatic txn(input bit ri, input bit rd, input bit we,
                     input logic [31:0] ia, input logic [31:0] da,
                     input logic [31:0] wd, input int lat,
                     input logic [31:0] val, input bit scr, input bit keep);
    bit          side;
    bit          wr;
    bit          tmo;
    bit          got;
    int          cnt;
    logic [31:0] nd;
    resp_t       r;
    l2x_t        x;
    side = arb_pick(ri, rd);
`ifdef L2_ARB_RR_EN
    m_last = side;
`endif
    wr  = side && we;
    tmo = (lat == 0) || (lat > TMO);
    nd  = tmo ? 32'd0 : (wr ? m_dc_rd : val);
    if (side) m_dc_rd = nd; else m_ic_rd = nd;
    r.side = side; r.err = tmo; r.ic_rd = m_ic_rd; r.dc_rd = m_dc_rd;
    r.nb = tmo ? TMO : lat;
    x.wr = wr; x.addr = side ? da : ia; x.wdata = wd;
    rq.push_back(r);
    lq.push_back(x);

    ic_req = ri; dc_req = rd; ic_addr = ia; dc_addr = da;
    dc_we = we; dc_wdata = wd;
    l2_ready = 1'($urandom_range(0, 1));
    l2_rdata = $urandom;

    cnt = 0; got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cnt++;
      if (busy) begin
        got = 1'b1;
        break;
      end
      l2_ready = 1'($urandom_range(0, 1));
    end
    chk("busy_entry_delay", cnt, from_resp ? 2 : 1);

    got = 1'b0;
    for (int k = 1; k <= TMO + 4; k++) begin
      if (ic_ready || dc_ready) begin
        got = 1'b1;
        break;
      end
      l2_ready = (k == lat);
      l2_rdata = (k == lat) ? val : $urandom;
      if (scr && k == 1) begin
        ic_req = 1'b0; dc_req = 1'b0;
        ic_addr = $urandom; dc_addr = $urandom;
        dc_we = ~dc_we; dc_wdata = $urandom;
      end
      @(negedge clk);
    end
    chk("ready_within_bound", 32'(got), 32'd1);

    l2_ready = 1'($urandom_range(0, 1));
    l2_rdata = $urandom;
    if (!keep) begin
      ic_req = 1'b0; dc_req = 1'b0;
      @(negedge clk);
      l2_ready = 1'b0;
    end
    from_resp = keep;
  endtask

  // Monitor
  initial begin
    bit    prev_busy;
    int    scnt;
    resp_t r;
    l2x_t  x;
    prev_busy = 1'b0;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
        scnt = 0;
      end else begin
        if (l2_read || l2_write) scnt++;
        chk("strobe_exclusive", 32'(l2_read & l2_write), 32'd0);
        chk("err_without_ready", {30'd0, ic_err & ~ic_ready, dc_err & ~dc_ready}, 32'd0);
        if (busy && !prev_busy) begin
          if (lq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_busy: got busy=1 expected no transaction");
          end else begin
            x = lq.pop_front();
            chk("l2_read", 32'(l2_read), 32'(!x.wr));
            chk("l2_write", 32'(l2_write), 32'(x.wr));
            chk("l2_addr", l2_addr, x.addr);
            if (x.wr) chk("l2_wdata", l2_wdata, x.wdata);
          end
        end
        if (ic_ready || dc_ready) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready: got ic_ready=%b dc_ready=%b expected none", ic_ready, dc_ready);
          end else begin
            r = rq.pop_front();
            txn_no++;
            chk("ready_side", {30'd0, ic_ready, dc_ready}, r.side ? 32'd1 : 32'd2);
            chk("ic_rdata", ic_rdata, r.ic_rd);
            chk("dc_rdata", dc_rdata, r.dc_rd);
            chk("owner_err", 32'(r.side ? dc_err : ic_err), 32'(r.err));
            chk("strobe_cycles", scnt, r.nb);
            $display("txn %0d: side=%s ic_rdata=%h dc_rdata=%h err=%b strobes=%0d",
                     txn_no, r.side ? "D" : "I", ic_rdata, dc_rdata,
                     r.side ? dc_err : ic_err, scnt);
          end
          scnt = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    l2x_t x;
    int   sel;
    int   lat;
    bit   got;
    rst_n = 1'b0; ic_req = 1'b0; ic_addr = 32'd0; dc_req = 1'b0; dc_we = 1'b0;
    dc_addr = 32'd0; dc_wdata = 32'd0; l2_rdata = 32'd0; l2_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", {30'd0, ic_ready, dc_ready}, 32'd0);
    chk("rst_err", {30'd0, ic_err, dc_err}, 32'd0);
    chk("rst_strobes", {30'd0, l2_read, l2_write}, 32'd0);
    chk("rst_l2_addr", l2_addr, 32'd0);
    chk("rst_l2_wdata", l2_wdata, 32'd0);
    chk("rst_ic_rdata", ic_rdata, 32'd0);
    chk("rst_dc_rdata", dc_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Minimum-latency I read
    txn(1, 0, 0, 32'h1000, 32'h0, 32'h0, 1, 32'hCAFEF00D, 0, 0);
    // D write, l2_ready in 5th BUSY cycle; dc_rdata must stay 0
    txn(0, 1, 1, 32'h0, 32'h2040, 32'h12345678, 5, 32'hDEADBEEF, 0, 0);
    // Completion in the very last allowed BUSY cycle
    txn(0, 1, 0, 32'h0, 32'h2080, 32'h0, TMO, 32'hA5A55A5A, 0, 0);
    // Timeout on a D read
    txn(0, 1, 0, 32'h0, 32'h20C0, 32'h0, 0, 32'h0, 0, 0);
    // Four back-to-back conflicts
    for (int i = 0; i < 4; i++) begin
      txn(1, 1, 0, 32'h3000, 32'h4000, 32'h0, 1 + (i % 3),
          32'h100 + 32'(i), 0, (i != 3));
    end

    // Reset in the 3rd BUSY cycle of an I read
    x.wr = 1'b0; x.addr = 32'h5000; x.wdata = 32'h0;
    lq.push_back(x);
    ic_req = 1'b1; ic_addr = 32'h5000; l2_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst_test_busy_seen", 32'(got), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midbusy_l2_read", 32'(l2_read), 32'd0);
    chk("midbusy_busy", 32'(busy), 32'd0);
    ic_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("midbusy_rdata", ic_rdata | dc_rdata, 32'd0);
    rst_n = 1'b1;
`ifdef L2_ARB_RR_EN
    m_last = 1'b1;
`endif
    m_ic_rd = 32'd0; m_dc_rd = 32'd0; from_resp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_ready_after_reset", {30'd0, ic_ready, dc_ready}, 32'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(1, 3);
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO + 1));
      txn(sel[0], sel[1], 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
          lat, $urandom, (sel[0] ^ sel[1]) && ($urandom_range(0, 1) == 1), 0);
    end

    repeat (3) @(negedge clk);
    chk("pending_responses", rq.size(), 32'd0);
    chk("pending_l2", lq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_l2_arbiter.md
RISCV_L2_ARBITER -- requirements
Module: riscv_l2_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of BUSY cycles to wait for l2_ready (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ic_req  input  1  I-side read request, held until ic_ready.
REQ-005 SHALL have port ic_addr  input  32  I-side address, stable while ic_req=1.
REQ-006 SHALL have ports ic_rdata/ic_ready/ic_err  output  32/1/1  I-side read data, one-cycle completion pulse, and timeout flag.
REQ-007 SHALL have ports dc_req/dc_we  input  1/1  D-side request and write-enable (1=write, 0=read).
REQ-008 SHALL have ports dc_addr/dc_wdata  input  32/32  D-side address and write data, stable while dc_req=1.
REQ-009 SHALL have ports dc_rdata/dc_ready/dc_err  output  32/1/1  D-side read data, completion pulse, and timeout flag.
REQ-010 SHALL have ports l2_addr/l2_wdata  output  32/32  registered L2 address and write data.
REQ-011 SHALL have ports l2_read/l2_write  output  1/1  registered L2 strobes.
REQ-012 SHALL have ports l2_rdata/l2_ready  input  32/1  L2 read data and completion.
REQ-013 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-014 SHALL implement three states: IDLE, BUSY, and RESP.
REQ-015 IDLE: if any req=1 at a clock edge, SHALL latch owner, addr, we, and wdata, then enter BUSY; else SHALL remain in IDLE.
REQ-016 BUSY: SHALL drive l2_addr/l2_wdata from the latch and hold l2_read=!we or l2_write=we for every BUSY cycle; both SHALL never be high together.
REQ-017 BUSY with l2_ready=1 at an edge: SHALL capture l2_rdata into the owner's rdata (read only; writes leave rdata unchanged), then enter RESP.
REQ-018 RESP: SHALL deassert l2_read/l2_write, raise the owner's ready for exactly one cycle, then enter IDLE; the non-owner's ready SHALL stay 0.
REQ-019 Minimum latency SHALL be req in cycle 0, l2 strobe in cycle 1, ready in cycle 2 (when l2_ready=1 in cycle 1).
REQ-020 The timeout counter (16 bit) SHALL clear on BUSY entry and increment each BUSY cycle; if it reaches TIMEOUT-1 with l2_ready=0, the block SHALL enter RESP with owner err=1, owner rdata=32'h0.
REQ-021 err SHALL be valid only while the matching ready=1, and SHALL be 0 otherwise.
REQ-022 l2_ready SHALL be ignored in IDLE and RESP.
REQ-023 A req deasserted during BUSY SHALL be ignored; the transaction SHALL complete and ready SHALL still pulse.
REQ-024 Input changes to ic_*/dc_* during BUSY or RESP SHALL not affect the in-flight transaction.
REQ-025 A requester MAY reassert req in the cycle after its ready; it SHALL then be arbitrated in the following IDLE.
REQ-026 When both reqs are high in IDLE, the winner SHALL follow REQ-030/031; the loser SHALL keep waiting with no ready.

Reset
REQ-027 On rst_n=0, the block SHALL asynchronously force state=IDLE, with all ready/err/l2_read/l2_write/busy=0, all rdata/l2_addr/l2_wdata=0, counter=0, and last_grant=D.
REQ-028 Reset mid-BUSY SHALL drop l2_read/l2_write immediately and lose the transaction, with no ready pulse after release.
REQ-029 The first arbitration SHALL occur at the first edge with rst_n=1.

Configuration
REQ-030 With L2_ARB_RR_EN defined: round-robin; on conflict the block SHALL grant the side not in last_grant, updating last_grant on every grant (after reset, I wins the first conflict).
REQ-031 Without L2_ARB_RR_EN: fixed priority; on conflict D SHALL always win; last_grant SHALL be absent or unused.

Verification
REQ-032 The bench SHALL cover: ic_req, addr 0x1000, with l2_ready=1 in the first BUSY cycle and l2_rdata=0xCAFEF00D -> l2_read in cycle 1, ic_ready=1 with ic_rdata=0xCAFEF00D in cycle 2, ic_err=0.
REQ-033 The bench SHALL cover: dc_req, dc_we=1, addr 0x2040, wdata 0x12345678, with l2_ready after 5 cycles -> l2_write=1 for 5 cycles, l2_read=0, single dc_ready pulse, dc_rdata unchanged.
REQ-034 The bench SHALL cover: ic_req and dc_req both held for 4 transactions -> with L2_ARB_RR_EN, grants I,D,I,D; without it, grants D,D,D,D and ic_ready=0 throughout.
REQ-035 The bench SHALL cover: TIMEOUT=8, dc_req read, l2_ready held 0 -> RESP after 8 BUSY cycles, dc_ready=1, dc_err=1, dc_rdata=0.
REQ-036 The bench SHALL cover: rst_n=0 asserted in the 3rd BUSY cycle -> l2_read=0 and busy=0 immediately, with no ready pulse after release.
